// File: rtl/message_feeder.sv
// message_feeder
//
// Buffers a short message of letter codes (0..25) and plays it, one character
// at a time, into a downstream Enigma/bombe model. Each character is presented
// on char_out with a one-cycle key_press strobe; the feeder then waits for ack,
// captures cipher_in into result, idles for GAP cycles and moves on. If ack
// never arrives within TIMEOUT cycles the playback is aborted with err set.
//
// Parameters
//   DEPTH    buffer capacity in characters (power of two, 2..64)
//   GAP      idle cycles between presses (1..255)
//   TIMEOUT  cycles to wait for ack before aborting
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   wr_en      load strobe, one character per cycle (IDLE only)
//   wr_char    character to load, 0..25
//   play       start playback (level, acted on in IDLE)
//   ack        downstream has produced its letter
//   cipher_in  downstream letter, valid with ack
//   char_out   character presented downstream
//   key_press  one-cycle strobe per presented character
//   result     last cipher_in captured on ack
//   count      number of stored characters
//   busy       playback active
//   done       one-cycle completion pulse
//   err        sticky error flag
//
// Build option
//   MESSAGE_FEEDER_ECHO_EN  when defined, each acknowledged cipher letter is
//   written back over the character that produced it, so replaying the buffer
//   through a reciprocal machine recovers the plaintext.

module message_feeder #(
    parameter int DEPTH   = 16,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_char,
    input  logic                     play,
    input  logic                     ack,
    input  logic [7:0]               cipher_in,
    output logic [7:0]               char_out,
    output logic                     key_press,
    output logic [7:0]               result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_idx_reg, rd_idx_next;
    logic [GW-1:0]   gap_cnt_reg;
    logic [TW-1:0]   tmo_cnt_reg;
    logic [7:0]      char_out_reg;
    logic [7:0]      result_reg;
    logic            done_reg, done_next;
    logic            err_reg;

    logic            err_set;
    logic            wr_accept;
    logic            rd_load;
    logic            ack_take;
    logic            echo_we;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [7:0]      mem_wdata;

    logic [7:0]      mem [DEPTH];

    // Next-state and control decode
    always_comb begin
        state_next  = state_reg;
        rd_idx_next = rd_idx_reg;
        done_next   = 1'b0;
        err_set     = 1'b0;
        wr_accept   = 1'b0;
        rd_load     = 1'b0;
        ack_take    = 1'b0;

        if (wr_en) begin
            if (state_reg != S_IDLE || wr_char > 8'd25 || count_reg == CW'(DEPTH))
                err_set = 1'b1;
            else
                wr_accept = 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (play) begin
                    if (count_reg != '0) begin
                        state_next  = S_PRESS;
                        rd_idx_next = '0;
                        rd_load     = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            S_PRESS: begin
                // ack is not looked at here, so an ack coincident with
                // key_press is never taken as the answer.
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    ack_take   = 1'b1;
                    state_next = S_GAP;
                end else if (tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_GAP: begin
                // GAP idle cycles, then one decision cycle that also fetches
                // the next character for the coming PRESS.
                if (gap_cnt_reg == GW'(GAP)) begin
                    if ({1'b0, rd_idx_reg} == count_reg - CW'(1)) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        rd_idx_next = rd_idx_reg + AW'(1);
                        rd_load     = 1'b1;
                        state_next  = S_PRESS;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef MESSAGE_FEEDER_ECHO_EN
    assign echo_we = ack_take;
`else
    assign echo_we = 1'b0;
`endif

    // Loads happen only in IDLE and echoes only in WAIT_ACK, so one write
    // port serves both.
    assign mem_we    = (wr_accept || echo_we) && !reset;
    assign mem_waddr = echo_we ? rd_idx_reg : wr_ptr_reg;
    assign mem_wdata = echo_we ? cipher_in  : wr_char;

    // Buffer storage: left unreset so it maps onto block RAM; reset empties
    // the buffer logically by clearing count and pointers.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_idx_reg   <= '0;
            gap_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            char_out_reg <= 8'd0;
            result_reg   <= 8'd0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rd_idx_reg <= rd_idx_next;
            done_reg   <= done_next;
            if (err_set)
                err_reg <= 1'b1;
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                count_reg  <= count_reg + CW'(1);
            end
            tmo_cnt_reg <= (state_reg == S_WAIT_ACK) ? tmo_cnt_reg + TW'(1) : '0;
            gap_cnt_reg <= (state_reg == S_GAP) ? gap_cnt_reg + GW'(1) : '0;
            // Registered buffer read, loaded as PRESS is entered; held until
            // the next character is fetched.
            if (rd_load)
                char_out_reg <= mem[rd_idx_next];
            if (ack_take)
                result_reg <= cipher_in;
        end
    end

    assign char_out  = char_out_reg;
    assign key_press = (state_reg == S_PRESS);
    assign result    = result_reg;
    assign count     = count_reg;
    assign busy      = (state_reg == S_PRESS) || (state_reg == S_WAIT_ACK) || (state_reg == S_GAP);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_message_feeder.sv
// Testbench for message_feeder (default parameters DEPTH=16, GAP=4,
// TIMEOUT=1023). Load behaviour is checked from a vector table; playback,
// timeout, mid-playback reset and replay are checked with directed sequences.

module tb_message_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_char;
    logic       play;
    logic       ack;
    logic [7:0] cipher_in;
    logic [7:0] char_out;
    logic       key_press;
    logic [7:0] result;
    logic [4:0] count;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    message_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_char   (wr_char),
        .play      (play),
        .ack       (ack),
        .cipher_in (cipher_in),
        .char_out  (char_out),
        .key_press (key_press),
        .result    (result),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] ch;
        int         exp_count;
        int         exp_err;
    } vec_t;

    vec_t vecs [24];

    // Playback observations
    int press_cnt;
    int press_cyc [8];
    int press_chr [8];
    int done_cnt;
    int done_cyc;
    int busy_first;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; play = 1'b0; ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [7:0] ch);
        wr_en = 1'b1; wr_char = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses play, then watches for budget cycles. Cycle 0 is the first cycle
    // after play is sampled. ack_dly < 0 means never acknowledge. rst_press>0
    // asserts reset in the cycle after that press (inside WAIT_ACK).
    task automatic watch(input int ack_dly, input logic [7:0] cbase,
                         input int budget, input int rst_press);
        int ack_at;
        int rst_cyc;
        press_cnt = 0; done_cnt = 0; done_cyc = -1; busy_first = 0;
        ack_at = -1; rst_cyc = -10;
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (c == 0) busy_first = int'(busy);
            if (c == rst_cyc + 1) begin
                chk("reset_abort_busy", int'(busy), 0);
                chk("reset_abort_count", int'(count), 0);
            end
            if (key_press) begin
                if (press_cnt < 8) begin
                    press_cyc[press_cnt] = c;
                    press_chr[press_cnt] = int'(char_out);
                end
                $display("press %0d at cycle %0d char_out=%0d", press_cnt, c, char_out);
                press_cnt++;
                if (ack_dly >= 0) ack_at = c + ack_dly;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            ack       = (c == ack_at);
            cipher_in = cbase + 8'(press_cnt - 1);
            if (rst_press > 0 && press_cnt == rst_press && rst_cyc < 0
                && c == press_cyc[rst_press-1] + 1) begin
                reset   = 1'b1;
                rst_cyc = c;
            end else begin
                reset = 1'b0;
            end
            @(negedge clk);
        end
        ack = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_char = 8'd0; play = 1'b0;
        ack = 1'b0; cipher_in = 8'd0;
        @(negedge clk);

        // Reset state
        chk("rst_count", int'(count), 0);
        chk("rst_char_out", int'(char_out), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_key_press", int'(key_press), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;

        // Load vectors
        vecs[0] = '{1'b0, 1'b1, 8'd3,  1, 0};
        vecs[1] = '{1'b0, 1'b1, 8'd7,  2, 0};
        vecs[2] = '{1'b0, 1'b1, 8'd25, 3, 0};
        vecs[3] = '{1'b0, 1'b1, 8'd26, 3, 1};
        vecs[4] = '{1'b0, 1'b0, 8'd0,  3, 1};
        vecs[5] = '{1'b1, 1'b1, 8'd9,  0, 0};
        for (int i = 0; i < 16; i++)
            vecs[6+i] = '{1'b0, 1'b1, 8'(i + 5), i + 1, 0};
        vecs[22] = '{1'b0, 1'b1, 8'd5, 16, 1};
        vecs[23] = '{1'b0, 1'b0, 8'd0, 16, 1};

        for (int i = 0; i < 24; i++) begin
            reset = vecs[i].rst; wr_en = vecs[i].wr; wr_char = vecs[i].ch;
            @(negedge clk);
            $display("vec %0d: rst=%0d wr=%0d ch=%0d -> count=%0d err=%0d",
                     i, vecs[i].rst, vecs[i].wr, vecs[i].ch, count, err);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d_err", i), int'(err), vecs[i].exp_err);
        end
        reset = 1'b0; wr_en = 1'b0;

        // Play with an empty buffer: done pulse only
        do_reset();
        watch(-1, 8'd0, 4, 0);
        chk("empty_busy", busy_first, 0);
        chk("empty_done_cnt", done_cnt, 1);
        chk("empty_presses", press_cnt, 0);

        // Three-character playback, ack two cycles after each press
        do_reset();
        load(8'd0); load(8'd1); load(8'd2);
        watch(2, 8'd10, 30, 0);
        chk("play_busy_first", busy_first, 1);
        chk("play_presses", press_cnt, 3);
        chk("play_chr0", press_chr[0], 0);
        chk("play_chr1", press_chr[1], 1);
        chk("play_chr2", press_chr[2], 2);
        chk("play_space01", press_cyc[1] - press_cyc[0], 8);
        chk("play_space12", press_cyc[2] - press_cyc[1], 8);
        chk("play_result", int'(result), 12);
        chk("play_done_cnt", done_cnt, 1);
        chk("play_done_cyc", done_cyc, press_cyc[2] + 8);
        chk("play_busy_end", int'(busy), 0);
        chk("play_err", int'(err), 0);
        chk("play_count_kept", int'(count), 3);

        // Timeout: no ack ever
        do_reset();
        load(8'd6);
        watch(-1, 8'd0, 1100, 0);
        chk("tmo_presses", press_cnt, 1);
        chk("tmo_done_cnt", done_cnt, 1);
        chk("tmo_done_delay", done_cyc - press_cyc[0], 1024);
        chk("tmo_err", int'(err), 1);
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_count_kept", int'(count), 1);

        // Reset during WAIT_ACK of the second character
        do_reset();
        load(8'd5); load(8'd6); load(8'd7);
        watch(2, 8'd20, 40, 2);
        chk("rstmid_presses", press_cnt, 2);
        chk("rstmid_done_cnt", done_cnt, 0);
        chk("rstmid_busy", int'(busy), 0);

        // Replay after one acknowledged character
        do_reset();
        load(8'd4);
        watch(2, 8'd9, 12, 0);
        chk("echo_first_chr", press_chr[0], 4);
        chk("echo_result", int'(result), 9);
        watch(2, 8'd9, 12, 0);
        chk("echo_presses", press_cnt, 1);
`ifdef MESSAGE_FEEDER_ECHO_EN
        chk("echo_second_chr", press_chr[0], 9);
`else
        chk("echo_second_chr", press_chr[0], 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
